frame_read_ctrl: RTL and testbench

//  Upstream feeder for the VGA display stage. Fetches a 240x320 RGB565 image from the frame cache in raster order.

---
 rtl/frame_read_ctrl_if.sv | 13 +
 rtl/frame_read_ctrl.sv | 174 +++++++++++++++++
 tb/tb_frame_read_ctrl.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/frame_read_ctrl_if.sv
// Frame-cache read port: request/accept address channel plus in-order data return.
interface frame_read_ctrl_if #(
  parameter int unsigned ADDR_W = 17
) ();
  logic              MEM_RREQ;
  logic [ADDR_W-1:0] MEM_RADDR;
  logic              MEM_RACK;
  logic              MEM_RVALID;
  logic [15:0]       MEM_RDATA;

  modport master (output MEM_RREQ, MEM_RADDR, input MEM_RACK, MEM_RVALID, MEM_RDATA);
  modport slave  (input MEM_RREQ, MEM_RADDR, output MEM_RACK, MEM_RVALID, MEM_RDATA);
endinterface

// File: rtl/frame_read_ctrl.sv
// Raster-order frame prefetcher feeding the VGA pixel mux through a credit-limited FIFO.
// Optional colour-bar test pattern on pops when FRC_TEST_PATTERN_EN is defined.
module frame_read_ctrl #(
  parameter int unsigned IMG_W           = 240,
  parameter int unsigned IMG_H           = 320,
  parameter int unsigned ADDR_W          = 17,
  parameter int unsigned FIFO_AW         = 4,
  parameter logic [15:0] UNDERFLOW_COLOR = 16'hF800
) (
  input  logic              CLK_40M,
  input  logic              RST_N,
  input  logic              VSYNC_IN,
  input  logic              PIX_RD,
`ifdef FRC_TEST_PATTERN_EN
  input  logic              TP_SEL,
`endif
  output logic [15:0]       PIX_DATA,
  frame_read_ctrl_if.master mem,
  output logic              UNDERFLOW,
  output logic              FRAME_DONE
);
  localparam int unsigned NPIX   = IMG_W * IMG_H;
  localparam int unsigned DEPTH  = 2 ** FIFO_AW;
  localparam int unsigned PTR_W  = FIFO_AW + 1;
  localparam int unsigned CRED_W = FIFO_AW + 2;
  localparam int unsigned DISC_W = FIFO_AW + 3;
  localparam logic [ADDR_W-1:0] END_ADDR  = ADDR_W'(NPIX);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
`ifdef FRC_TEST_PATTERN_EN
  localparam int unsigned COL_W = $clog2(IMG_W);
  localparam int unsigned BAR_W = IMG_W / 8;
  localparam logic [15:0] BAR_COLOR [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                            16'hF81F, 16'hF800, 16'h001F, 16'h0000};
`endif

  typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_FETCH, S_DONE} state_t;

  state_t              state_q, state_d;
  logic                vsync_q, vsync_prev_q;
  logic                rreq_q, rreq_d;
  logic [ADDR_W-1:0]   raddr_q, raddr_d;
  logic [PTR_W-1:0]    outst_q, outst_d;
  logic [DISC_W-1:0]   disc_q, disc_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [15:0]         pix_q, pix_d;
  logic                underflow_q, underflow_d;
  logic                frame_done_q, frame_done_d;
  logic [ADDR_W-1:0]   push_cnt_q, push_cnt_d;
  logic [15:0]         fifo_mem [DEPTH];
`ifdef FRC_TEST_PATTERN_EN
  logic [COL_W-1:0]    col_q, col_d;
`endif

  logic                frame_start, ack, drop, push, pop_ok, empty, full;
  logic [PTR_W-1:0]    count, count_d;
  logic [CRED_W-1:0]   credit_d;

  // Stale returns (requested before the last flush) are dropped, never pushed
  assign frame_start = vsync_prev_q & ~vsync_q;
  assign count       = wr_ptr_q - rd_ptr_q;
  assign empty       = (count == '0);
  assign full        = (count == PTR_W'(DEPTH));
  assign ack         = rreq_q & mem.MEM_RACK;
  assign drop        = mem.MEM_RVALID & ((state_q == S_FLUSH) | (disc_q != '0));
  assign push        = mem.MEM_RVALID & ~drop;
  assign pop_ok      = PIX_RD & ~empty & (state_q != S_FLUSH);

  always_comb begin
    state_d      = state_q;
    raddr_d      = raddr_q + ADDR_W'(ack);
    outst_d      = outst_q + PTR_W'(ack) - PTR_W'(push);
    disc_d       = disc_q - DISC_W'(drop);
    wr_ptr_d     = wr_ptr_q + PTR_W'(push);
    rd_ptr_d     = rd_ptr_q + PTR_W'(pop_ok);
    pix_d        = pix_q;
    underflow_d  = underflow_q;
    frame_done_d = push && (push_cnt_q == LAST_ADDR);
    push_cnt_d   = push_cnt_q + ADDR_W'(push);
`ifdef FRC_TEST_PATTERN_EN
    col_d        = col_q;
`endif

    // Pop sees the FIFO as it was before this cycle's push
    if (PIX_RD && state_q != S_FLUSH) begin
      if (empty) begin
        pix_d       = UNDERFLOW_COLOR;
        underflow_d = 1'b1;
      end else begin
        pix_d = fifo_mem[rd_ptr_q[FIFO_AW-1:0]];
      end
`ifdef FRC_TEST_PATTERN_EN
      if (TP_SEL) pix_d = BAR_COLOR[3'(col_q / COL_W'(BAR_W))];
      col_d = (col_q == COL_W'(IMG_W - 1)) ? '0 : col_q + COL_W'(1);
`endif
    end

    unique case (state_q)
      S_IDLE:  if (frame_start) state_d = S_FLUSH;
      S_FLUSH: begin
        state_d     = S_FETCH;
        wr_ptr_d    = '0;
        rd_ptr_d    = '0;
        raddr_d     = '0;
        underflow_d = 1'b0;
        push_cnt_d  = '0;
        outst_d     = '0;
        disc_d      = disc_q + DISC_W'(outst_q) - DISC_W'(mem.MEM_RVALID);
        if (PIX_RD) pix_d = UNDERFLOW_COLOR;
`ifdef FRC_TEST_PATTERN_EN
        col_d       = '0;
`endif
      end
      S_FETCH: if (raddr_q == END_ADDR && outst_q == '0) state_d = S_DONE;
      S_DONE:  ;
      default: state_d = S_IDLE;
    endcase
    if (frame_start) state_d = S_FLUSH;

    // Request is registered from next-cycle values so credits are exact
    count_d  = wr_ptr_d - rd_ptr_d;
    credit_d = CRED_W'(count_d) + CRED_W'(outst_d);
    rreq_d   = (state_d == S_FETCH) && (credit_d < CRED_W'(DEPTH)) && (raddr_d < END_ADDR);
  end

  always_ff @(posedge CLK_40M or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= S_IDLE;
      vsync_q      <= 1'b1;
      vsync_prev_q <= 1'b1;
      rreq_q       <= 1'b0;
      raddr_q      <= '0;
      outst_q      <= '0;
      disc_q       <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      pix_q        <= '0;
      underflow_q  <= 1'b0;
      frame_done_q <= 1'b0;
      push_cnt_q   <= '0;
`ifdef FRC_TEST_PATTERN_EN
      col_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      vsync_q      <= VSYNC_IN;
      vsync_prev_q <= vsync_q;
      rreq_q       <= rreq_d;
      raddr_q      <= raddr_d;
      outst_q      <= outst_d;
      disc_q       <= disc_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      pix_q        <= pix_d;
      underflow_q  <= underflow_d;
      frame_done_q <= frame_done_d;
      push_cnt_q   <= push_cnt_d;
`ifdef FRC_TEST_PATTERN_EN
      col_q        <= col_d;
`endif
    end
  end

  always_ff @(posedge CLK_40M) begin
    if (push) fifo_mem[wr_ptr_q[FIFO_AW-1:0]] <= mem.MEM_RDATA;
  end

  a_no_overflow: assert property (@(posedge CLK_40M) disable iff (!RST_N) !(push && full));

  assign PIX_DATA      = pix_q;
  assign UNDERFLOW     = underflow_q;
  assign FRAME_DONE    = frame_done_q;
  assign mem.MEM_RREQ  = rreq_q;
  assign mem.MEM_RADDR = raddr_q;
endmodule

// File: tb/tb_frame_read_ctrl.sv
// Self-checking bench for frame_read_ctrl: cache model with tagged in-order returns and a
// queue-based FIFO reference; directed frames followed by a randomized phase.
module tb_frame_read_ctrl;
  localparam int unsigned IMG_W  = 240;
  localparam int unsigned IMG_H  = 320;
  localparam int unsigned ADDR_W = 17;
  localparam int          NPIX   = IMG_W * IMG_H;
  localparam logic [15:0] UCOL   = 16'hF800;
  localparam logic [15:0] BAR_REF [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                          16'hF81F, 16'hF800, 16'h001F, 16'h0000};

  typedef struct { int addr; int ep; int due; } req_t;

  logic        CLK_40M = 1'b0;
  logic        RST_N, VSYNC_IN, PIX_RD;
  logic [15:0] PIX_DATA;
  logic        UNDERFLOW, FRAME_DONE;
  logic        TP_SEL;

  frame_read_ctrl_if #(.ADDR_W(ADDR_W)) mif ();

  frame_read_ctrl #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W), .FIFO_AW(4),
                    .UNDERFLOW_COLOR(UCOL)) dut (
    .CLK_40M   (CLK_40M),
    .RST_N     (RST_N),
    .VSYNC_IN  (VSYNC_IN),
    .PIX_RD    (PIX_RD),
`ifdef FRC_TEST_PATTERN_EN
    .TP_SEL    (TP_SEL),
`endif
    .PIX_DATA  (PIX_DATA),
    .mem       (mif),
    .UNDERFLOW (UNDERFLOW),
    .FRAME_DONE(FRAME_DONE)
  );

  always #5 CLK_40M = ~CLK_40M;

  int n_assert = 0, n_fail = 0;
  req_t        cq[$];
  logic [15:0] mq[$];
  int  t = 0, last_due = 0, ep = 0, exp_addr = 0, col = 0;
  int  lat_lo = 3, lat_hi = 3, ack_budget = -1;
  int  n_ack = 0, first_ack_t = 0, last_ack_t = 0, last_ack_addr = -1, n_fd = 0, n_pop_ok = 0;
  bit  m_active = 0, flush_now = 0, vq_m = 1, vp_m = 1, tp = 0;
  logic [15:0] exp_pix = '0;
  logic        exp_uf = 1'b0, exp_fd = 1'b0;

  function automatic logic [15:0] data_fn(input int a, input int e);
    return 16'(a + (e - 1) * 977);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    cq.delete(); mq.delete();
    m_active = 0; flush_now = 0; vq_m = 1; vp_m = 1; exp_addr = 0; col = 0;
    exp_pix = '0; exp_uf = 1'b0; exp_fd = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge CLK_40M);
    RST_N = 1'b0; VSYNC_IN = 1'b1; PIX_RD = 1'b0; TP_SEL = 1'b0; tp = 0;
    mif.MEM_RACK = 1'b0; mif.MEM_RVALID = 1'b0; mif.MEM_RDATA = '0;
    #1;
    chk("rst_pix", 32'(PIX_DATA), 32'(0));
    chk("rst_rreq", 32'(mif.MEM_RREQ), 32'(0));
    chk("rst_raddr", 32'(mif.MEM_RADDR), 32'(0));
    chk("rst_underflow", 32'(UNDERFLOW), 32'(0));
    chk("rst_frame_done", 32'(FRAME_DONE), 32'(0));
    repeat (2) @(negedge CLK_40M);
    model_reset();
    RST_N = 1'b1;
  endtask

  // One clock: check registered outputs, drive this cycle's inputs, advance the reference
  task automatic step(input bit vs, input bit rd, input bit rk);
    int credit, lat, due;
    bit rv, rk_eff, flush_next;
    req_t r;
    @(negedge CLK_40M);
    chk("pix_data", 32'(PIX_DATA), 32'(exp_pix));
    chk("underflow", 32'(UNDERFLOW), 32'(exp_uf));
    chk("frame_done", 32'(FRAME_DONE), 32'(exp_fd));
    if (FRAME_DONE === 1'b1) n_fd++;
    credit = mq.size();
    foreach (cq[i]) if (cq[i].ep == ep) credit++;
    if (mif.MEM_RREQ === 1'b1) begin
      chk("rreq_allowed", 32'(m_active && !flush_now && credit < 16 && exp_addr < NPIX), 32'(1));
      chk("raddr_order", 32'(mif.MEM_RADDR), 32'(exp_addr));
    end
    rk_eff = rk && (ack_budget != 0);
    rv = 1'b0;
    if (cq.size() > 0 && cq[0].due <= t) begin
      rv = 1'b1;
      r = cq.pop_front();
    end
    VSYNC_IN = vs; PIX_RD = rd; TP_SEL = tp;
    mif.MEM_RACK = rk_eff; mif.MEM_RVALID = rv;
    mif.MEM_RDATA = rv ? data_fn(r.addr, r.ep) : 16'($urandom);
    if (mif.MEM_RREQ === 1'b1 && rk_eff) begin
      lat = $urandom_range(lat_hi, lat_lo);
      due = t + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      cq.push_back('{int'(mif.MEM_RADDR), ep, due});
      if (n_ack == 0) first_ack_t = t;
      last_ack_t = t; last_ack_addr = int'(mif.MEM_RADDR); n_ack++;
      if (ack_budget > 0) ack_budget--;
      exp_addr++;
    end
    if (rd) begin
      if (flush_now) exp_pix = UCOL;
      else if (mq.size() == 0) begin exp_pix = UCOL; exp_uf = 1'b1; end
      else begin exp_pix = mq.pop_front(); n_pop_ok++; end
`ifdef FRC_TEST_PATTERN_EN
      if (!flush_now) begin
        if (tp) exp_pix = BAR_REF[col / 30];
        col = (col == IMG_W - 1) ? 0 : col + 1;
      end
`endif
    end
    exp_fd = 1'b0;
    if (rv && !flush_now && r.ep == ep) begin
      mq.push_back(data_fn(r.addr, r.ep));
      if (r.addr == NPIX - 1) exp_fd = 1'b1;
    end
    if (flush_now) begin
      mq.delete(); exp_uf = 1'b0; ep++; exp_addr = 0; m_active = 1; col = 0;
    end
    flush_next = vp_m && !vq_m;
    vp_m = vq_m; vq_m = vs; flush_now = flush_next;
    t++;
  endtask

  initial begin
    do_reset();
    // Idle after reset: no requests while VSYNC stays high
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 1);
      chk("idle_rreq", 32'(mif.MEM_RREQ), 32'(0));
    end

    // Prefetch fill: 16 back-to-back requests, then credits exhausted
    n_ack = 0; n_fd = 0; lat_lo = 3; lat_hi = 3;
    step(0, 0, 1);
    for (int i = 0; i < 30; i++) step(1, 0, 1);
    chk("fill_acks", 32'(n_ack), 32'(16));
    chk("fill_b2b", 32'(last_ack_t - first_ack_t), 32'(15));
    chk("fill_rreq_off", 32'(mif.MEM_RREQ), 32'(0));
    chk("fill_fifo", 32'(mq.size()), 32'(16));

    // Full frame popped once per cycle
    n_pop_ok = 0;
    for (int i = 0; i < NPIX; i++) step(1, 1, 1);
    for (int i = 0; i < 10; i++) step(1, 0, 1);
    chk("frame_done_count", 32'(n_fd), 32'(1));
    chk("last_raddr", 32'(last_ack_addr), 32'(NPIX - 1));
    chk("frame_pops_ok", 32'(n_pop_ok), 32'(NPIX));
    chk("done_underflow", 32'(UNDERFLOW), 32'(0));
    chk("done_rreq", 32'(mif.MEM_RREQ), 32'(0));

    // Starved frame: every pop underflows, next frame start clears the flag
    step(0, 1, 0);
    for (int i = 0; i < 12; i++) step(1, 1, 0);
    chk("starve_pix", 32'(PIX_DATA), 32'(UCOL));
    chk("starve_underflow", 32'(UNDERFLOW), 32'(1));
    step(0, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 0);
    chk("uf_cleared", 32'(UNDERFLOW), 32'(0));

    // Restart with three requests in flight: their returns must be discarded
    lat_lo = 10; lat_hi = 10; n_ack = 0; ack_budget = 3;
    step(0, 0, 1);
    for (int i = 0; i < 50 && n_ack < 3; i++) step(1, 0, 1);
    chk("restart_acks", 32'(n_ack), 32'(3));
    ack_budget = -1;
    step(0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 0, 0);
    for (int i = 0; i < 60 && mq.size() == 0; i++) step(1, 0, 1);
    chk("restart_fifo_filled", 32'(mq.size() > 0), 32'(1));
    step(1, 1, 1);
    @(posedge CLK_40M); #1;
    chk("restart_first_pix", 32'(PIX_DATA), 32'(data_fn(0, ep)));

`ifdef FRC_TEST_PATTERN_EN
    // Colour bars: one bar per 30 pops
    lat_lo = 3; lat_hi = 3;
    step(0, 0, 1);
    for (int i = 0; i < 30; i++) step(1, 0, 1);
    tp = 1;
    for (int i = 0; i < IMG_W; i++) begin
      step(1, 1, 1);
      if (i % 30 == 0) begin
        @(posedge CLK_40M); #1;
        chk("tp_bar", 32'(PIX_DATA), 32'(BAR_REF[i / 30]));
      end
    end
    tp = 0;
`endif

    // Random traffic with periodic frame restarts and one mid-frame reset
    lat_lo = 1; lat_hi = 6;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        do_reset();
        step(1, 0, 1);
        chk("midreset_rreq", 32'(mif.MEM_RREQ), 32'(0));
      end
`ifdef FRC_TEST_PATTERN_EN
      tp = ($urandom_range(0, 3) == 0);
`endif
      step(!((i % 700) inside {5, 6}), $urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
